// File: rtl/sha256_pkg.sv
// SHA-256 shared types, round constants, initial hash value and bit-level helpers.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  state_t;

  // Engine FSM encoding
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Standard H0..H7, H0 in the top word
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  function automatic word_t ror(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Word-wise modular sum of two packed 8-word states (feed-forward)
  function automatic logic [255:0] add_state(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: packed a..h (a in the top word) plus K and W to next a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] vars_i,
  input  logic [31:0]  k_i,
  input  logic [31:0]  w_i,
  output logic [255:0] vars_o
);

  word_t a, b, c, d, e, f, g, h;
  word_t t1, t2;

  // Round function with all additions mod 2^32
  always_comb begin
    {a, b, c, d, e, f, g, h} = vars_i;
    t1 = h + bsig1(e) + ch(e, f, g) + k_i + w_i;
    t2 = bsig0(a) + maj(a, b, c);
    vars_o = {t1 + t2, a, b, c, d + t1, e, f, g};
  end

endmodule

// File: rtl/sha256_compress_engine.sv
// Full 64-round SHA-256 compression engine with ROUNDS_PER_CYCLE unrolling and valid/ready
// handshakes. Optional leading-zero hit flag is built when SHA_ZERO_CHECK_EN is defined.
module sha256_compress_engine
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned DIFFICULTY       = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_i,
  input  logic [255:0] state_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest_o,
  output logic         busy
`ifdef SHA_ZERO_CHECK_EN
  ,
  output logic         hit
`endif
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  if (DIFFICULTY > 256) begin : g_bad_difficulty
    $error("DIFFICULTY must not exceed 256");
  end

  state_t       state_q, state_d;
  logic [5:0]   rnd_q, rnd_d;
  logic [255:0] work_q, work_d;
  logic [255:0] saved_q, saved_d;
  logic [255:0] digest_q, digest_d;
  logic         out_valid_q, out_valid_d;
  word_t        w_q [16];
  word_t        w_d [16];

  // Window extended by the R freshly expanded words of this cycle
  word_t        ext [16+ROUNDS_PER_CYCLE];
  logic [255:0] round_out;

  // Chained round instances; stage j consumes K[rnd+j] and w[j]
  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
    logic [255:0] vars_in;
    logic [255:0] vars_out;
    word_t        k_sel;

    if (j == 0) begin : g_first
      assign vars_in = work_q;
    end else begin : g_next
      assign vars_in = g_round[j-1].vars_out;
    end

    assign k_sel = K[rnd_q + 6'(j)];

    sha256_round u_round (
      .vars_i (vars_in),
      .k_i    (k_sel),
      .w_i    (w_q[j]),
      .vars_o (vars_out)
    );
  end

  assign round_out = g_round[ROUNDS_PER_CYCLE-1].vars_out;

  // Message-schedule expansion: R new words appended after the current window
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ext[i] = w_q[i];
    end
    for (int k = 0; k < int'(ROUNDS_PER_CYCLE); k++) begin
      ext[16+k] = ssig1(ext[14+k]) + ext[9+k] + ssig0(ext[1+k]) + ext[k];
    end
  end

  // FSM and datapath next-state
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    work_d      = work_q;
    saved_d     = saved_q;
    digest_d    = digest_q;
    out_valid_d = out_valid_q;
    w_d         = w_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = state_i;
          saved_d = state_i;
          for (int i = 0; i < 16; i++) begin
            w_d[i] = block_i[511-32*i -: 32];
          end
          rnd_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = round_out;
        for (int i = 0; i < 16; i++) begin
          w_d[i] = ext[i+int'(ROUNDS_PER_CYCLE)];
        end
        rnd_d = rnd_q + 6'(ROUNDS_PER_CYCLE);
        if ({1'b0, rnd_q} + 7'(ROUNDS_PER_CYCLE) == 7'd64) begin
          digest_d    = add_state(saved_q, round_out);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      work_q      <= '0;
      saved_q     <= '0;
      digest_q    <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      work_q      <= work_d;
      saved_q     <= saved_d;
      digest_q    <= digest_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

`ifdef SHA_ZERO_CHECK_EN
  // Top DIFFICULTY bits of the digest must all be zero
  localparam logic [255:0] LzMask = ~({256{1'b1}} >> DIFFICULTY);

  logic hit_q, hit_d;

  // Hit is registered alongside the digest it describes
  always_comb begin
    hit_d = hit_q;
    if (state_q == RUN && out_valid_d) begin
      hit_d = ((digest_d & LzMask) == '0);
    end
  end

  // Hit register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit = hit_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_valid = out_valid_q;
  assign digest_o  = digest_q;

endmodule

// File: tb/tb_sha256_compress_engine.sv
// Self-checking bench: two engines (1 and 4 rounds per cycle) against a plain SHA-256 model.
module tb_sha256_compress_engine;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] IV_ST =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam int LAT  [2] = '{64, 16};
  localparam int DIFF [2] = '{0, 1};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk;
  logic         rst;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [511:0] blk       [2];
  logic [255:0] st        [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [255:0] dig       [2];
  logic         busy      [2];
`ifdef SHA_ZERO_CHECK_EN
  logic         hit       [2];
`endif

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sha256_compress_engine #(
    .ROUNDS_PER_CYCLE (1),
    .DIFFICULTY       (0)
  ) dut_r1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .block_i   (blk[0]),
    .state_i   (st[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .digest_o  (dig[0]),
    .busy      (busy[0])
`ifdef SHA_ZERO_CHECK_EN
    ,
    .hit       (hit[0])
`endif
  );

  sha256_compress_engine #(
    .ROUNDS_PER_CYCLE (4),
    .DIFFICULTY       (1)
  ) dut_r4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .block_i   (blk[1]),
    .state_i   (st[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .digest_o  (dig[1]),
    .busy      (busy[1])
`ifdef SHA_ZERO_CHECK_EN
    ,
    .hit       (hit[1])
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] s, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = s[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = s[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic int clz(input logic [255:0] x);
    int n;
    n = 0;
    for (int i = 255; i >= 0; i--) begin
      if (x[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- stimulus helpers (no comparisons) ----------------
  // Entered and left on a falling edge; returns just after the acceptance edge.
  task automatic start_block(input int d, input logic [511:0] b, input logic [255:0] s,
                             output bit ok);
    int n;
    n = 0;
    while (!in_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready[d];
    in_valid[d] = 1'b1;
    blk[d] = b;
    st[d] = s;
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    blk[d] = rand512();
    st[d] = rand256();
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_out(input int d);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl d=%0d: got rdy=%b vld=%b busy=%b, want 1 0 0",
                 d, in_ready[d], out_valid[d], busy[d]);
      end
      checks++;
      if (dig[d] !== 256'h0) begin
        errors++;
        $display("FAIL reset_digest d=%0d: got %h, want 0", d, dig[d]);
      end
`ifdef SHA_ZERO_CHECK_EN
      checks++;
      if (hit[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hit d=%0d: got %b, want 0", d, hit[d]);
      end
`endif
    end
  endtask

  task automatic test_known_vectors();
    int           kd [4];
    logic [511:0] kb [4];
    logic [255:0] ke [4];
    int           lat;
    bit           ok;
    kd = '{0, 1, 1, 0};
    kb = '{ABC_BLK, EMPTY_BLK, ABC_BLK, EMPTY_BLK};
    ke = '{ABC_DIG, EMPTY_DIG, ABC_DIG, EMPTY_DIG};
    for (int t = 0; t < 4; t++) begin
      start_block(kd[t], kb[t], IV_ST, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL kv_accept t=%0d: in_ready never seen", t);
      end
      checks++;
      if (busy[kd[t]] !== 1'b1 || in_ready[kd[t]] !== 1'b0) begin
        errors++;
        $display("FAIL kv_busy t=%0d: got busy=%b rdy=%b, want 1 0",
                 t, busy[kd[t]], in_ready[kd[t]]);
      end
      wait_out(kd[t], lat);
      checks++;
      if (lat != LAT[kd[t]]) begin
        errors++;
        $display("FAIL kv_latency t=%0d: got %0d, want %0d", t, lat, LAT[kd[t]]);
      end
      checks++;
      if (dig[kd[t]] !== ke[t]) begin
        errors++;
        $display("FAIL kv_digest t=%0d: got %h, want %h", t, dig[kd[t]], ke[t]);
      end
`ifdef SHA_ZERO_CHECK_EN
      checks++;
      if (hit[kd[t]] !== (clz(ke[t]) >= DIFF[kd[t]])) begin
        errors++;
        $display("FAIL kv_hit t=%0d: got %b, want %b", t, hit[kd[t]],
                 clz(ke[t]) >= DIFF[kd[t]]);
      end
`endif
      finish_out(kd[t]);
      checks++;
      if (out_valid[kd[t]] !== 1'b0 || in_ready[kd[t]] !== 1'b1) begin
        errors++;
        $display("FAIL kv_release t=%0d: got vld=%b rdy=%b, want 0 1",
                 t, out_valid[kd[t]], in_ready[kd[t]]);
      end
    end
  endtask

  task automatic test_random();
    logic [511:0] b;
    logic [255:0] s, e;
    int           lat;
    bit           ok;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 3; n++) begin
        b = rand512();
        s = rand256();
        e = ref_compress(s, b);
        start_block(d, b, s, ok);
        wait_out(d, lat);
        checks++;
        if (!ok || lat != LAT[d]) begin
          errors++;
          $display("FAIL rnd_latency d=%0d n=%0d: got %0d (acc=%b), want %0d",
                   d, n, lat, ok, LAT[d]);
        end
        checks++;
        if (dig[d] !== e) begin
          errors++;
          $display("FAIL rnd_digest d=%0d n=%0d: got %h, want %h", d, n, dig[d], e);
        end
`ifdef SHA_ZERO_CHECK_EN
        checks++;
        if (hit[d] !== (clz(e) >= DIFF[d])) begin
          errors++;
          $display("FAIL rnd_hit d=%0d n=%0d: got %b, want %b", d, n, hit[d],
                   clz(e) >= DIFF[d]);
        end
`endif
        finish_out(d);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    for (int d = 0; d < 2; d++) begin
      start_block(d, ABC_BLK, IV_ST, ok);
      wait_out(d, lat);
      checks++;
      if (!ok || lat != LAT[d]) begin
        errors++;
        $display("FAIL bp_latency d=%0d: got %0d, want %0d", d, lat, LAT[d]);
      end
      for (int i = 0; i < 10; i++) begin
        in_valid[d] = 1'b1;
        blk[d] = EMPTY_BLK;
        st[d] = IV_ST;
        checks++;
        if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || busy[d] !== 1'b1 ||
            dig[d] !== ABC_DIG) begin
          errors++;
          $display("FAIL bp_hold d=%0d i=%0d: got vld=%b rdy=%b busy=%b dig=%h, want 1 0 1 %h",
                   d, i, out_valid[d], in_ready[d], busy[d], dig[d], ABC_DIG);
        end
        @(negedge clk);
      end
      out_ready[d] = 1'b1;
      @(negedge clk);
      out_ready[d] = 1'b0;
      checks++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL bp_no_early_accept d=%0d: got vld=%b rdy=%b, want 0 1",
                 d, out_valid[d], in_ready[d]);
      end
      @(negedge clk);
      in_valid[d] = 1'b0;
      blk[d] = rand512();
      checks++;
      if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1) begin
        errors++;
        $display("FAIL bp_second_accept d=%0d: got rdy=%b busy=%b, want 0 1",
                 d, in_ready[d], busy[d]);
      end
      wait_out(d, lat);
      checks++;
      if (lat != LAT[d] || dig[d] !== EMPTY_DIG) begin
        errors++;
        $display("FAIL bp_second_digest d=%0d: got lat=%0d dig=%h, want %0d %h",
                 d, lat, dig[d], LAT[d], EMPTY_DIG);
      end
      finish_out(d);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit ok;
    bit seen;
    start_block(0, ABC_BLK, IV_ST, ok);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0 ||
        dig[0] !== 256'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got rdy=%b vld=%b busy=%b dig=%h, want 1 0 0 0",
               in_ready[0], out_valid[0], busy[0], dig[0]);
    end
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid[0] || out_valid[1]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_partial: got out_valid pulse, want none");
    end
    start_block(0, ABC_BLK, IV_ST, ok);
    wait_out(0, lat);
    checks++;
    if (!ok || lat != LAT[0] || dig[0] !== ABC_DIG) begin
      errors++;
      $display("FAIL midrst_rerun: got lat=%0d dig=%h, want %0d %h",
               lat, dig[0], LAT[0], ABC_DIG);
    end
    finish_out(0);
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      logic [511:0] bq [3];
      logic [255:0] sq [3];
      logic [255:0] eq [3];
      int sent, got, cyc, last;
      bit acc;
      sent = 0;
      got = 0;
      cyc = 0;
      last = 0;
      for (int i = 0; i < 3; i++) begin
        bq[i] = rand512();
        sq[i] = rand256();
        eq[i] = ref_compress(sq[i], bq[i]);
      end
      out_ready[d] = 1'b1;
      in_valid[d] = 1'b1;
      blk[d] = bq[0];
      st[d] = sq[0];
      while (got < 3 && cyc < 1000) begin
        acc = in_valid[d] && in_ready[d];
        @(negedge clk);
        cyc++;
        if (acc) begin
          sent++;
          if (sent < 3) begin
            blk[d] = bq[sent];
            st[d] = sq[sent];
          end else begin
            in_valid[d] = 1'b0;
          end
        end
        if (out_valid[d]) begin
          checks++;
          if (dig[d] !== eq[got]) begin
            errors++;
            $display("FAIL b2b_digest d=%0d n=%0d: got %h, want %h", d, got, dig[d], eq[got]);
          end
          if (got > 0) begin
            checks++;
            if (cyc - last != LAT[d] + 2) begin
              errors++;
              $display("FAIL b2b_period d=%0d n=%0d: got %0d, want %0d",
                       d, got, cyc - last, LAT[d] + 2);
            end
          end
          last = cyc;
          got++;
        end
      end
      checks++;
      if (got != 3) begin
        errors++;
        $display("FAIL b2b_count d=%0d: got %0d digests, want 3", d, got);
      end
      in_valid[d] = 1'b0;
      @(negedge clk);
      out_ready[d] = 1'b0;
      checks++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_idle d=%0d: got vld=%b rdy=%b, want 0 1",
                 d, out_valid[d], in_ready[d]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      blk[d]       = '0;
      st[d]        = '0;
    end
    @(negedge clk);
    test_reset();
    test_known_vectors();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
